if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have parameter HANDLER_PC, 32'h0000_4180, exception handler entry.
REQ-003 SHALL have parameters IM_BASE, 32'h0000_3000, and IM_TOP, 32'h0000_6FFC, the legal fetch window, inclusive.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports Stall  in  1  hazard hold from the hazard unit; Req  in  1  exception/interrupt flush from CP0; eret_ID  in  1  eret decoded in ID.
REQ-007 SHALL have ports NPCOp_ID  in  2  branch/jump select (0 = sequential); npcValue_ID  in  32  redirect target; isJump_ID  in  1  ID holds a control-transfer instruction; EPC  in  32  return address.
REQ-008 SHALL have ports Instr_IF  in  32  instruction-memory read data; PC_IF  out  32  instruction-memory address.
REQ-009 SHALL have ports Instr_ID, PC_ID  out  32 each; ExcCode_ID  out  5; BD_ID  out  1 (delay-slot flag); all registered IF/ID contents.

Function
REQ-010 PC_IF SHALL be a register; its next value SHALL follow this priority: Req -> HANDLER_PC; eret_ID -> EPC; Stall -> hold; NPCOp_ID != 0 -> npcValue_ID; else PC_IF + 4 (mod 2^32).
REQ-011 Fetch fault SHALL be PC_IF[1:0] != 0 or PC_IF < IM_BASE or PC_IF > IM_TOP; on fault the fetched word SHALL be replaced by 32'h0 and the fetch code SHALL be 5'd4 (AdEL), else 5'd0.
REQ-012 IF/ID update priority: Req -> Instr_ID=0, PC_ID=HANDLER_PC, ExcCode_ID=0, BD_ID=0; Stall -> hold all; eret_ID -> Instr_ID=0, PC_ID=EPC, ExcCode_ID=0, BD_ID=0 (no delay slot after eret); else load fetched word, PC_IF, fetch code, BD_ID=isJump_ID.
REQ-013 Req SHALL override Stall in the same cycle for both the PC and IF/ID.
REQ-014 The latency from PC_IF to Instr_ID/PC_ID SHALL be exactly one cycle when no stall is present.
REQ-015 The delay-slot instruction fetched while a branch sits in ID SHALL enter IF/ID normally; the redirect SHALL apply only to PC_IF.
REQ-016 A faulting fetch SHALL NOT itself alter PC sequencing; redirection to the handler SHALL occur only via Req.
REQ-017 PC wrap past 32'hFFFF_FFFC SHALL roll to 0 and be flagged AdEL by REQ-011.

Reset
REQ-018 On reset low, the block SHALL asynchronously set PC_IF=RESET_PC, Instr_ID=0, PC_ID=RESET_PC, ExcCode_ID=0, BD_ID=0.
REQ-019 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect; the first fetch after release SHALL be RESET_PC.
REQ-020 Release SHALL be sampled on the rising edge; the first PC update SHALL occur on the first edge with reset high.

Structure
REQ-021 RESET_PC, HANDLER_PC, IM_BASE, IM_TOP and the ExcCode constants (0 Int, 4 AdEL, 10 RI) SHALL live in the shared CPU definitions header used by the control and CP0 blocks.
REQ-022 The block SHALL contain a single sub-module, if_id_reg, holding the four IF/ID fields with stall/flush inputs; PC logic and fault detection SHALL stay in if_stage.

Verification
REQ-023 Reset release with no stall for 3 cycles -> PC_IF 0x3000, 0x3004, 0x3008; PC_ID lags by one cycle; ExcCode_ID=0.
REQ-024 Stall high 2 cycles at PC_IF=0x3008 -> PC_IF and all IF/ID outputs hold; resume -> 0x300C.
REQ-025 isJump_ID=1, NPCOp_ID=1, npcValue_ID=0x3100 at PC_IF=0x3010 -> next PC_IF=0x3100; Instr_ID gets the 0x3010 word with BD_ID=1.
REQ-026 npcValue_ID=0x3002 taken -> next cycle ExcCode_ID=4, Instr_ID=0, PC_ID=0x3002; npcValue_ID=0x7000 -> same AdEL result.
REQ-027 Req=1 with Stall=1 -> next PC_IF=0x4180, Instr_ID=0, PC_ID=0x4180, BD_ID=0.
REQ-028 eret_ID=1, EPC=0x3020 -> next PC_IF=0x3020, Instr_ID=0; reset low mid-sequence -> outputs immediately at reset values.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions: fetch window, reset/handler vectors, exception codes.
// Imported by the fetch stage and by the control / CP0 blocks.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_C   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_C = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_C    = 32'h0000_3000;
  localparam logic [31:0] IM_TOP_C     = 32'h0000_6FFC;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_RI   = 5'd10
  } exc_code_e;

  // Misaligned or outside the inclusive instruction-memory window.
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [31:0] top);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > top);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: ID/CP0/hazard controls in, instruction memory port, IF/ID contents out.
// slave = the fetch stage itself, master = the surrounding pipeline.
interface if_stage_if;

  logic        Stall;
  logic        Req;
  logic        eret_ID;
  logic [1:0]  NPCOp_ID;
  logic [31:0] npcValue_ID;
  logic        isJump_ID;
  logic [31:0] EPC;
  logic [31:0] Instr_IF;
  logic [31:0] PC_IF;
  logic [31:0] Instr_ID;
  logic [31:0] PC_ID;
  logic [4:0]  ExcCode_ID;
  logic        BD_ID;

  modport master (
    output Stall, Req, eret_ID, NPCOp_ID, npcValue_ID, isJump_ID, EPC, Instr_IF,
    input  PC_IF, Instr_ID, PC_ID, ExcCode_ID, BD_ID
  );

  modport slave (
    input  Stall, Req, eret_ID, NPCOp_ID, npcValue_ID, isJump_ID, EPC, Instr_IF,
    output PC_IF, Instr_ID, PC_ID, ExcCode_ID, BD_ID
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats eret, else load the fetch.
// One-cycle latency; stall holds every field.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_C,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  exc_in,
  input  logic        bd_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [4:0]  exc_out,
  output logic        bd_out
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;
  logic [4:0]  exc_d, exc_q;
  logic        bd_d, bd_q;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    if (flush) begin
      instr_d = 32'h0;
      pc_d    = HANDLER_PC;
      exc_d   = EXC_INT;
      bd_d    = 1'b0;
    end else if (stall) begin
      // hold
    end else if (eret) begin
      // eret has no delay slot: bubble tagged with the return address
      instr_d = 32'h0;
      pc_d    = epc;
      exc_d   = EXC_INT;
      bd_d    = 1'b0;
    end else begin
      instr_d = instr_in;
      pc_d    = pc_in;
      exc_d   = exc_in;
      bd_d    = bd_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= 32'h0;
      pc_q    <= RESET_PC;
      exc_q   <= EXC_INT;
      bd_q    <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign exc_out   = exc_q;
  assign bd_out    = bd_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register with Req > eret > Stall > redirect > +4 priority, AdEL fetch check.
// PC_IF to Instr_ID/PC_ID is one cycle; Stall holds PC and IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_C,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_C,
  parameter logic [31:0] IM_BASE    = IM_BASE_C,
  parameter logic [31:0] IM_TOP     = IM_TOP_C
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.slave  bus
);

  logic [31:0] pc_d, pc_q;
  logic        fault;
  logic [31:0] fetch_instr;
  logic [4:0]  fetch_exc;
  logic [31:0] instr_id, pc_id;
  logic [4:0]  exc_id;
  logic        bd_id;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (bus.Req)                    pc_d = HANDLER_PC;
    else if (bus.eret_ID)           pc_d = bus.EPC;
    else if (bus.Stall)             pc_d = pc_q;
    else if (bus.NPCOp_ID != 2'd0)  pc_d = bus.npcValue_ID;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // A faulting fetch only poisons the word; the handler is reached via Req from CP0.
  always_comb begin
    fault       = fetch_fault(pc_q, IM_BASE, IM_TOP);
    fetch_instr = fault ? 32'h0 : bus.Instr_IF;
    fetch_exc   = fault ? EXC_ADEL : EXC_INT;
  end

  if_id_reg #(
    .RESET_PC   (RESET_PC),
    .HANDLER_PC (HANDLER_PC)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .stall     (bus.Stall),
    .flush     (bus.Req),
    .eret      (bus.eret_ID),
    .epc       (bus.EPC),
    .instr_in  (fetch_instr),
    .pc_in     (pc_q),
    .exc_in    (fetch_exc),
    .bd_in     (bus.isJump_ID),
    .instr_out (instr_id),
    .pc_out    (pc_id),
    .exc_out   (exc_id),
    .bd_out    (bd_id)
  );

  assign bus.PC_IF      = pc_q;
  assign bus.Instr_ID   = instr_id;
  assign bus.PC_ID      = pc_id;
  assign bus.ExcCode_ID = exc_id;
  assign bus.BD_ID      = bd_id;

endmodule

// File: tb/tb_if_stage.sv
// Directed per-cycle vectors for the fetch stage plus hand sequences around async reset.
// Instruction memory is modelled as word = PC ^ 32'hDEAD_0000.
module tb_if_stage;

  logic clk;
  logic reset;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.Instr_IF = bus.PC_IF ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic        eret;
    logic [1:0]  npcop;
    logic [31:0] npcval;
    logic        isjump;
    logic [31:0] epc;
    logic [31:0] e_pc_if;
    logic [31:0] e_instr;
    logic [31:0] e_pc_id;
    logic [4:0]  e_exc;
    logic        e_bd;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic st, input logic rq, input logic er, input logic [1:0] op,
                     input logic [31:0] nv, input logic ij, input logic [31:0] ep,
                     input logic [31:0] pc_if, input logic [31:0] ins, input logic [31:0] pc_id,
                     input logic [4:0] exc, input logic bd);
    vec_t v;
    v.stall = st; v.req = rq; v.eret = er; v.npcop = op; v.npcval = nv;
    v.isjump = ij; v.epc = ep;
    v.e_pc_if = pc_if; v.e_instr = ins; v.e_pc_id = pc_id; v.e_exc = exc; v.e_bd = bd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc_if, input logic [31:0] ins,
                           input logic [31:0] pc_id, input logic [4:0] exc, input logic bd);
    check({tag, ".PC_IF"},      bus.PC_IF, pc_if);
    check({tag, ".Instr_ID"},   bus.Instr_ID, ins);
    check({tag, ".PC_ID"},      bus.PC_ID, pc_id);
    check({tag, ".ExcCode_ID"}, {27'h0, bus.ExcCode_ID}, {27'h0, exc});
    check({tag, ".BD_ID"},      {31'h0, bus.BD_ID}, {31'h0, bd});
  endtask

  task automatic drive(input logic st, input logic rq, input logic er, input logic [1:0] op,
                       input logic [31:0] nv, input logic ij, input logic [31:0] ep);
    bus.Stall = st; bus.Req = rq; bus.eret_ID = er; bus.NPCOp_ID = op;
    bus.npcValue_ID = nv; bus.isJump_ID = ij; bus.EPC = ep;
  endtask

  initial begin
    //   st rq er op  npcval        ij epc            PC_IF          Instr_ID       PC_ID          exc bd
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3004, 32'hDEAD_3000, 32'h0000_3000, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3008, 32'hDEAD_3004, 32'h0000_3004, 0, 0);
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3008, 32'hDEAD_3004, 32'h0000_3004, 0, 0);
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3008, 32'hDEAD_3004, 32'h0000_3004, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_300C, 32'hDEAD_3008, 32'h0000_3008, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3010, 32'hDEAD_300C, 32'h0000_300C, 0, 0);
    add(0, 0, 0, 1, 32'h3100,     1, 32'h0,        32'h0000_3100, 32'hDEAD_3010, 32'h0000_3010, 0, 1);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3104, 32'hDEAD_3100, 32'h0000_3100, 0, 0);
    add(0, 0, 0, 1, 32'h3002,     0, 32'h0,        32'h0000_3002, 32'hDEAD_3104, 32'h0000_3104, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3006, 32'h0,         32'h0000_3002, 4, 0);
    add(0, 0, 0, 2, 32'h7000,     0, 32'h0,        32'h0000_7000, 32'h0,         32'h0000_3006, 4, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_7004, 32'h0,         32'h0000_7000, 4, 0);
    add(0, 0, 0, 1, 32'h3020,     0, 32'h0,        32'h0000_3020, 32'h0,         32'h0000_7004, 4, 0);
    add(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_4180, 32'h0,         32'h0000_4180, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 32'h0,        32'h0000_4184, 32'hDEAD_4180, 32'h0000_4180, 0, 1);
    add(1, 0, 1, 0, 32'h0,        0, 32'h3020,     32'h0000_3020, 32'hDEAD_4180, 32'h0000_4180, 0, 1);
    add(0, 0, 1, 0, 32'h0,        1, 32'h3040,     32'h0000_3040, 32'h0,         32'h0000_3040, 0, 0);
    add(1, 0, 0, 1, 32'h5000,     0, 32'h0,        32'h0000_3040, 32'h0,         32'h0000_3040, 0, 0);
    add(0, 1, 1, 0, 32'h0,        0, 32'h3300,     32'h0000_4180, 32'h0,         32'h0000_4180, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_4184, 32'hDEAD_4180, 32'h0000_4180, 0, 0);
    add(0, 0, 0, 1, 32'hFFFF_FFFC,0, 32'h0,        32'hFFFF_FFFC, 32'hDEAD_4184, 32'h0000_4184, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 32'h0,         32'hFFFF_FFFC, 4, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 32'h0,         32'h0000_0000, 4, 0);
    add(0, 0, 0, 3, 32'h6FFC,     0, 32'h0,        32'h0000_6FFC, 32'h0,         32'h0000_0004, 4, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_7000, 32'hDEAD_6FFC, 32'h0000_6FFC, 0, 0);

    drive(0, 0, 0, 2'd0, 32'h0, 0, 32'h0);
    reset = 1'b0;
    #12;
    check_all("reset", 32'h0000_3000, 32'h0, 32'h0000_3000, 5'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].req, vecs[i].eret, vecs[i].npcop,
            vecs[i].npcval, vecs[i].isjump, vecs[i].epc);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc_if, vecs[i].e_instr,
                vecs[i].e_pc_id, vecs[i].e_exc, vecs[i].e_bd);
    end

    // Async reset in the middle of an eret/redirect sequence
    drive(0, 0, 1, 2'd1, 32'h5000, 1, 32'h3020);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 32'h0000_3000, 32'h0, 32'h0000_3000, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 32'h0000_3000, 32'h0, 32'h0000_3000, 5'd0, 1'b0);
    drive(0, 0, 0, 2'd0, 32'h0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release.PC_IF", bus.PC_IF, 32'h0000_3000);
    @(posedge clk);
    #1;
    check_all("first_fetch", 32'h0000_3004, 32'hDEAD_3000, 32'h0000_3000, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
